// File: rtl/processor_b_banked_pkg.sv
// Shared definitions for the banked GF(2^m) elimination cell.
package processor_b_banked_pkg;

  // Default field: GF(2^12) reduced by x^12 + x^3 + 1
  localparam int unsigned DEF_WIDTH = 12;
  localparam logic [12:0] DEF_POLY  = 13'h1009;

  typedef logic [1:0] op_t;

  // Operation encodings carried on op_in / op_out
  localparam op_t OP_PASS   = 2'b00;
  localparam op_t OP_SWAP   = 2'b01;
  localparam op_t OP_ELIM   = 2'b10;
  localparam op_t OP_INVADD = 2'b11;

endpackage

// File: rtl/processor_b_banked_gf_mul_red.sv
// Combinational GF(2^WIDTH) multiplier: shift-and-add with the reduction
// folded into every shift, so the running multiple never leaves WIDTH bits.
module gf_mul_red
  import processor_b_banked_pkg::*;
#(
  parameter int unsigned      WIDTH = DEF_WIDTH,
  parameter logic [WIDTH:0]   POLY  = DEF_POLY
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] p_o
);

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] sh;

  // Accumulate a*x^i for each set bit of b, keeping a*x^i reduced
  always_comb begin
    acc = '0;
    sh  = a_i;
    for (int i = 0; i < WIDTH; i++) begin
      if (b_i[i]) acc = acc ^ sh;
      sh = {sh[WIDTH-2:0], 1'b0} ^ (sh[WIDTH-1] ? POLY[WIDTH-1:0] : '0);
    end
    p_o = acc;
  end

endmodule

// File: rtl/processor_b_banked.sv
// Banked processing cell of a GF(2^m) systolic eliminator. Holds DEPTH
// folded rows in a register bank, one entry touched per valid beat, and
// forwards control/factor downstream with a single register stage.
module processor_b_banked
  import processor_b_banked_pkg::*;
#(
  parameter int unsigned    WIDTH = DEF_WIDTH,
  parameter logic [WIDTH:0] POLY  = DEF_POLY,
  parameter int unsigned    DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_in,
  input  logic             start_in,
  input  logic [1:0]       op_in,
  input  logic             flush_in,
  input  logic [WIDTH-1:0] data_in,
  input  logic [WIDTH-1:0] fac_in,
  output logic             valid_out,
  output logic             start_out,
  output logic [1:0]       op_out,
  output logic [WIDTH-1:0] fac_out,
  output logic [WIDTH-1:0] data_out,
  output logic [WIDTH-1:0] r_out
);

  localparam int unsigned      PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST  = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] bank_q [DEPTH];
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] idx;
  logic [WIDTH-1:0] rd;
  logic [WIDTH-1:0] mul_a;
  logic [WIDTH-1:0] prod;
  logic             wr_en;
  logic [WIDTH-1:0] wr_data;
  logic [WIDTH-1:0] dat_d, r_d;

  logic             vld_q, start_q;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] fac_q, dat_q, r_q;

  // A start beat always addresses entry 0, restarting any sweep in progress
  assign idx   = start_in ? '0 : ptr_q;
  assign rd    = bank_q[idx];
  // Inv-add multiplies the incoming element; every other op scales the bank row
  assign mul_a = (op_in == OP_INVADD) ? data_in : rd;

  gf_mul_red #(
    .WIDTH (WIDTH),
    .POLY  (POLY)
  ) u_mul (
    .a_i (mul_a),
    .b_i (fac_in),
    .p_o (prod)
  );

  // Decode the op into the downstream result and the bank write for this beat
  always_comb begin
    wr_en   = 1'b0;
    wr_data = '0;
    dat_d   = data_in;
    if (flush_in) begin
      dat_d   = rd;
      wr_en   = 1'b1;
      wr_data = '0;
    end else begin
      case (op_in)
        OP_PASS: begin
          dat_d = data_in;
        end
        OP_SWAP: begin
          dat_d   = rd;
          wr_en   = 1'b1;
          wr_data = data_in;
        end
        OP_ELIM: begin
          dat_d = prod ^ data_in;
        end
        default: begin
          dat_d   = rd;
          wr_en   = 1'b1;
          wr_data = prod;
        end
      endcase
    end
    // r_out reports the entry as it stands after this beat
    r_d   = wr_en ? wr_data : rd;
    ptr_d = (idx == LAST) ? '0 : idx + 1'b1;
  end

  // Row bank: only the addressed entry is written, the rest stay bit-stable
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) bank_q[i] <= '0;
    end else if (valid_in && wr_en) begin
      bank_q[idx] <= wr_data;
    end
  end

  // Sweep pointer advances only on valid beats
  always_ff @(posedge clk) begin
    if (rst)           ptr_q <= '0;
    else if (valid_in) ptr_q <= ptr_d;
  end

  // Output stage: valid follows every cycle, payload holds across gaps
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q   <= 1'b0;
      start_q <= 1'b0;
      op_q    <= '0;
      fac_q   <= '0;
      dat_q   <= '0;
      r_q     <= '0;
    end else begin
      vld_q <= valid_in;
      if (valid_in) begin
        start_q <= start_in;
        op_q    <= op_in;
        fac_q   <= fac_in;
        dat_q   <= dat_d;
        r_q     <= r_d;
      end
    end
  end

  assign valid_out = vld_q;
  assign start_out = start_q;
  assign op_out    = op_q;
  assign fac_out   = fac_q;
  assign data_out  = dat_q;
  assign r_out     = r_q;

endmodule

// File: tb/tb_processor_b_banked.sv
// Scoreboard bench for processor_b_banked in GF(16), x^4+x+1, four rows.
module tb_processor_b_banked;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         valid_in = 1'b0;
  logic         start_in = 1'b0;
  logic [1:0]   op_in = 2'b00;
  logic         flush_in = 1'b0;
  logic [W-1:0] data_in = '0;
  logic [W-1:0] fac_in = '0;
  logic         valid_out, start_out;
  logic [1:0]   op_out;
  logic [W-1:0] fac_out, data_out, r_out;

  processor_b_banked #(
    .WIDTH (W),
    .POLY  (5'h13),
    .DEPTH (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .start_in  (start_in),
    .op_in     (op_in),
    .flush_in  (flush_in),
    .data_in   (data_in),
    .fac_in    (fac_in),
    .valid_out (valid_out),
    .start_out (start_out),
    .op_out    (op_out),
    .fac_out   (fac_out),
    .data_out  (data_out),
    .r_out     (r_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] d;
    logic [W-1:0] r;
    logic [W-1:0] fac;
    logic [1:0]   op;
    logic         st;
  } exp_t;

  exp_t   q[$];
  exp_t   last_exp;
  logic [W-1:0] mbank [4];
  int     mptr;
  bit     mon_en = 1'b0;
  int     n_cmp = 0;
  int     n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference multiply: full carry-less product, then reduce from the top down
  function automatic logic [W-1:0] gf_ref(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [7:0] p;
    logic [7:0] poly;
    p = '0;
    poly = 8'h13;
    for (int i = 0; i < W; i++) if (b[i]) p = p ^ (8'(a) << i);
    for (int i = 6; i >= 4; i--) if (p[i]) p = p ^ (poly << (i - 4));
    return p[3:0];
  endfunction

  task automatic beat(input logic st, input logic [1:0] op, input logic fl,
                      input logic [W-1:0] d, input logic [W-1:0] f);
    int   ix;
    exp_t e;
    logic [W-1:0] old;
    ix  = st ? 0 : mptr;
    old = mbank[ix];
    e.st = st; e.op = op; e.fac = f;
    if (fl) begin
      e.d = old; mbank[ix] = '0;
    end else begin
      case (op)
        2'b00: e.d = d;
        2'b01: begin e.d = old; mbank[ix] = d; end
        2'b10: e.d = gf_ref(old, f) ^ d;
        default: begin e.d = old; mbank[ix] = gf_ref(d, f); end
      endcase
    end
    e.r  = mbank[ix];
    mptr = (ix + 1) % 4;
    q.push_back(e);
    valid_in = 1'b1; start_in = st; op_in = op; flush_in = fl;
    data_in = d; fac_in = f;
    @(posedge clk); #1;
    valid_in = 1'b0;
  endtask

  task automatic idle(input int n);
    valid_in = 1'b0;
    start_in = 1'($urandom);
    op_in    = 2'($urandom);
    flush_in = 1'($urandom);
    data_in  = W'($urandom);
    fac_in   = W'($urandom);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reset with a live beat on the same edge; that beat must be discarded
  task automatic do_reset();
    rst = 1'b1;
    valid_in = 1'b1; start_in = 1'b0; op_in = 2'b01; flush_in = 1'b0;
    data_in = 4'hA; fac_in = 4'h3;
    @(negedge clk); #1;
    mon_en = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    valid_in = 1'b0;
    chk("rst_valid", valid_out, 0);
    chk("rst_data",  data_out, 0);
    chk("rst_r",     r_out, 0);
    chk("rst_op",    op_out, 0);
    chk("rst_fac",   fac_out, 0);
    chk("rst_start", start_out, 0);
    for (int i = 0; i < 4; i++) mbank[i] = '0;
    mptr = 0;
    last_exp = '0;
    mon_en = 1'b1;
  endtask

  // Pop and compare on every output beat; across gaps the payload must hold
  always @(negedge clk) begin
    if (mon_en) begin
      if (valid_out) begin
        if (q.size() == 0) begin
          chk("unexpected_valid", valid_out, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("data_out",  data_out, e.d);
          chk("r_out",     r_out, e.r);
          chk("op_out",    op_out, e.op);
          chk("fac_out",   fac_out, e.fac);
          chk("start_out", start_out, e.st);
          last_exp = e;
        end
      end else begin
        chk("hold_data", data_out, last_exp.d);
        chk("hold_r",    r_out, last_exp.r);
        chk("hold_op",   op_out, last_exp.op);
      end
    end
  end

  initial begin
    mptr = 0;
    last_exp = '0;
    for (int i = 0; i < 4; i++) mbank[i] = '0;
    repeat (2) @(posedge clk); #1;
    do_reset();

    // Load the bank with swaps; pointer wraps back to 0
    beat(1, 2'b01, 0, 4'h5, 4'h0);
    beat(0, 2'b01, 0, 4'h6, 4'h0);
    beat(0, 2'b01, 0, 4'h7, 4'h0);
    beat(0, 2'b01, 0, 4'h9, 4'h0);
    idle(1);
    // Elim-add on row 0: 5*8 + 1 = F
    beat(1, 2'b10, 0, 4'h1, 4'h8);
    idle(1);
    // Inv-add on row 0: out 5, row becomes 2*8 = 3
    beat(1, 2'b11, 0, 4'h2, 4'h8);
    beat(0, 2'b00, 0, 4'hA, 4'h1);
    beat(0, 2'b10, 1, 4'hB, 4'h2);   // flush overrides elim at idx2
    beat(0, 2'b00, 0, 4'h4, 4'h0);   // row 3 still 9
    // Gaps and a restart mid-sweep
    beat(1, 2'b00, 0, 4'hE, 4'h0);
    idle(3);
    beat(0, 2'b01, 0, 4'hC, 4'h0);
    idle(2);
    beat(1, 2'b01, 0, 4'hD, 4'h0);
    beat(0, 2'b00, 0, 4'h0, 4'h0);
    beat(0, 2'b00, 0, 4'h0, 4'h0);
    beat(0, 2'b00, 0, 4'h0, 4'h0);
    idle(1);

    // Random mixed traffic
    for (int k = 0; k < 60; k++) begin
      beat(($urandom_range(0, 7) == 0), 2'($urandom), ($urandom_range(0, 7) == 0),
           W'($urandom), W'($urandom));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end

    // Reset with pointer at 2, then an unstarted swap must land in row 0
    beat(1, 2'b01, 0, 4'h3, 4'h0);
    beat(0, 2'b01, 0, 4'h8, 4'h0);
    do_reset();
    idle(1);
    beat(0, 2'b01, 0, 4'h5, 4'h0);
    beat(1, 2'b00, 0, 4'h1, 4'h0);
    beat(0, 2'b00, 0, 4'h2, 4'h0);
    idle(3);

    chk("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/processor_b_banked.md
PROCESSOR_B_BANKED -- requirements
Module: processor_b_banked

Interface
REQ-001 Parameter WIDTH, default 12: field element width m of GF(2^m).
REQ-002 Parameter POLY, default 13'h1009: reduction polynomial (x^12+x^3+1), WIDTH+1 bits, bit WIDTH set.
REQ-003 Parameter DEPTH, default 4: number of folded rows held (r-bank entries); DEPTH>=2.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 valid_in  input  1  beat qualifier for all other inputs.
REQ-007 start_in  input  1  first beat of a column sweep.
REQ-008 op_in  input  2  00 pass, 01 swap, 10 elim-add, 11 inv-add.
REQ-009 flush_in  input  1  flush mode; overrides op_in.
REQ-010 data_in  input  WIDTH  element from upstream cell.
REQ-011 fac_in  input  WIDTH  multiplier factor.
REQ-012 valid_out, start_out  output  1 each  registered copies of valid_in, start_in.
REQ-013 op_out  output  2  registered op_in.
REQ-014 fac_out  output  WIDTH  registered fac_in.
REQ-015 data_out  output  WIDTH  registered result to downstream cell.
REQ-016 r_out  output  WIDTH  registered copy of bank entry just written or read (idx of last valid beat).

Function
REQ-017 Beat index idx = 0 when start_in=1, else ptr; ptr (log2 DEPTH bits) updates to idx+1 on each valid beat, wrapping DEPTH-1 -> 0.
REQ-018 All outputs appear exactly 1 cycle after the valid beat; no combinational input-to-output path.
REQ-019 Field ops: product a*b carry-less, reduced mod POLY; add = bitwise XOR.
REQ-020 pass: data_out = data_in; bank unchanged.
REQ-021 swap: data_out = r[idx]; r[idx] <= data_in.
REQ-022 elim-add: data_out = r[idx]*fac_in + data_in; bank unchanged.
REQ-023 inv-add: data_out = r[idx] (old); r[idx] <= data_in*fac_in.
REQ-024 flush (flush_in=1, any op): data_out = r[idx]; r[idx] <= 0; op_out forwarded unchanged.
REQ-025 valid_in=0: no bank or ptr change; valid_out=0 next cycle; data_out, r_out, op_out, fac_out, start_out hold last values.
REQ-026 start_in=1 while ptr mid-sweep: sweep restarts at idx 0; no error flag.
REQ-027 Only r[idx] changes per beat; other entries bit-stable.
REQ-028 Inputs with bits above WIDTH-1 do not exist; products never exceed WIDTH bits after reduction.

Reset
REQ-029 rst=1 at an edge: all bank entries, ptr, and every output register cleared to 0 (valid_out=0), regardless of valid_in.
REQ-030 rst asserted mid-sweep discards the in-flight beat; first valid beat after release uses idx 0 even without start_in.

Structure
REQ-031 Shared package holds op encodings (OP_PASS, OP_SWAP, OP_ELIM, OP_INVADD) and default WIDTH/POLY constants.
REQ-032 One sub-module, gf_mul_red: combinational WIDTH x WIDTH multiply with POLY reduction; instantiated once, operands muxed by op (inv-add: data_in, fac_in; otherwise r[idx], fac_in).
REQ-033 Bank is a register array (DEPTH x WIDTH), not inferred RAM, reset by rst.

Verification (WIDTH=4, POLY=5'h13, DEPTH=4)
REQ-034 Reset then swap beats start, data 5,6,7,9 -> data_out 0,0,0,0; r_out 5,6,7,9; ptr wraps to 0.
REQ-035 Bank {5,6,7,9}, elim-add start, fac 8, data 1 at idx0 -> data_out F one cycle later; bank unchanged.
REQ-036 inv-add idx0, data 2, fac 8 with r[0]=5 -> data_out 5, r[0] becomes 3.
REQ-037 flush at idx2 with r[2]=7 -> data_out 7, r[2]=0; subsequent pass at idx3 -> data_out = data_in, r[3]=9 intact.
REQ-038 valid_in gaps between beats -> valid_out low, outputs held, ptr unchanged; start_in mid-sweep -> next write at idx0.
REQ-039 rst mid-sweep at ptr=2 -> all outputs 0 next cycle; next valid beat without start_in writes idx0.
